// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: decodes SYNC/CMD/ADDR/DATA/CHK frames into register-bank reads/writes.
// Build option: define UART_CMD_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle clocks.
module uart_cmd_parser #(
    parameter int          NREG           = 16,
    parameter logic [7:0]  SYNC           = 8'hA5,
    parameter logic [7:0]  ACK            = 8'h06,
    parameter logic [7:0]  NAK            = 8'h15,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_done,
    input  logic [7:0]          rx_data,
    input  logic                tx_busy,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic [8*NREG-1:0]   regs_out,
    output logic                wr_strobe,
    output logic [3:0]          wr_addr,
    output logic [7:0]          err_count
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CMD    = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_DATA   = 4'd3;
    localparam logic [3:0] S_CHK    = 4'd4;
    localparam logic [3:0] S_EXEC   = 4'd5;
    localparam logic [3:0] S_TX_REQ = 4'd6;
    localparam logic [3:0] S_TX_HI  = 4'd7;
    localparam logic [3:0] S_TX_LO  = 4'd8;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    logic [3:0]            state;
    logic                  rx_done_q;
    logic                  byte_vld;
    logic [7:0]            byte_q;
    logic [7:0]            cmd_r, addr_r, data_r, chk_r;
    logic [7:0]            rd_data;
    logic                  rd_pending;
    logic [NREG-1:0][7:0]  regs;
    logic                  in_frame;
    logic                  frame_ok;
    logic                  nak_evt, drop_evt, to_hit;
    logic [9:0]            err_sum;

    assign regs_out = regs;
    assign tx_start = (state == S_TX_REQ) && !tx_busy;
    assign in_frame = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);

    assign frame_ok = (chk_r == (cmd_r ^ addr_r ^ data_r))
                   && ((cmd_r == CMD_WR) || (cmd_r == CMD_RD))
                   && (addr_r < 8'(NREG));

    assign nak_evt  = (state == S_EXEC) && !frame_ok;
    assign drop_evt = byte_vld && ((state == S_EXEC) || (state == S_TX_REQ) ||
                                   (state == S_TX_HI) || (state == S_TX_LO));

    // A NAK and a dropped byte can land in the same EXEC cycle; both are counted.
    assign err_sum = {2'b00, err_count} + {9'd0, nak_evt} + {9'd0, drop_evt} + {9'd0, to_hit};

`ifdef UART_CMD_TIMEOUT_EN
    logic [23:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || !in_frame || byte_vld)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 24'd1;
    end

    assign to_hit = in_frame && !byte_vld && (to_cnt == TIMEOUT_CYCLES);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rx_done_q  <= 1'b0;
            byte_vld   <= 1'b0;
            byte_q     <= '0;
            cmd_r      <= '0;
            addr_r     <= '0;
            data_r     <= '0;
            chk_r      <= '0;
            rd_data    <= '0;
            rd_pending <= 1'b0;
            regs       <= '0;
            tx_data    <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            err_count  <= '0;
        end else begin
            // Rising edge of rx_done yields exactly one accepted byte, one cycle later.
            rx_done_q <= rx_done;
            byte_vld  <= rx_done && !rx_done_q;
            byte_q    <= rx_data;
            wr_strobe <= 1'b0;
            err_count <= (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];

            case (state)
                S_IDLE: if (byte_vld && byte_q == SYNC) state <= S_CMD;
                S_CMD: begin
                    if (byte_vld) begin
                        cmd_r <= byte_q;
                        state <= S_ADDR;
                    end else if (to_hit) state <= S_IDLE;
                end
                S_ADDR: begin
                    if (byte_vld) begin
                        addr_r <= byte_q;
                        state  <= S_DATA;
                    end else if (to_hit) state <= S_IDLE;
                end
                S_DATA: begin
                    if (byte_vld) begin
                        data_r <= byte_q;
                        state  <= S_CHK;
                    end else if (to_hit) state <= S_IDLE;
                end
                S_CHK: begin
                    if (byte_vld) begin
                        chk_r <= byte_q;
                        state <= S_EXEC;
                    end else if (to_hit) state <= S_IDLE;
                end
                S_EXEC: begin
                    // Read data is captured here so a later write cannot alter an in-flight reply.
                    rd_pending <= frame_ok && (cmd_r == CMD_RD);
                    rd_data    <= regs[addr_r[AW-1:0]];
                    tx_data    <= frame_ok ? ACK : NAK;
                    if (frame_ok && cmd_r == CMD_WR) begin
                        regs[addr_r[AW-1:0]] <= data_r;
                        wr_strobe            <= 1'b1;
                        wr_addr              <= addr_r[3:0];
                    end
                    state <= S_TX_REQ;
                end
                S_TX_REQ: if (!tx_busy) state <= S_TX_HI;
                S_TX_HI:  if (tx_busy)  state <= S_TX_LO;
                S_TX_LO: begin
                    if (!tx_busy) begin
                        if (rd_pending) begin
                            tx_data    <= rd_data;
                            rd_pending <= 1'b0;
                            state      <= S_TX_REQ;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboarded bench for uart_cmd_parser: byte-level RX driver, behavioural TX model, write monitor.
module tb_uart_cmd_parser;
`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [23:0] TO = 24'd100;
`else
    localparam logic [23:0] TO = 24'd5000000;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_done = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         tx_busy = 1'b0;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic [127:0] regs_out;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic [7:0]   err_count;

    uart_cmd_parser #(.NREG(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .err_count(err_count)
    );

    always #10 clk = ~clk;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0]  exp_tx[$];
    logic [11:0] exp_wr[$];
    logic        start_seen = 1'b0;
    int          busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rg(input int a);
        return regs_out[8*a +: 8];
    endfunction

    // Transmitter model: busy rises one cycle after tx_start, stays high for 6 cycles.
    always @(negedge clk) begin
        logic       s;
        logic [7:0] d;
        s = tx_start;
        d = tx_data;
        if (rst) begin
            start_seen = 1'b0;
            busy_cnt   = 0;
            tx_busy    = 1'b0;
        end else begin
            if (start_seen) begin
                start_seen = 1'b0;
                tx_busy    = 1'b1;
                busy_cnt   = 6;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (s) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
                else                    chk("tx_data", {24'd0, d}, {24'd0, exp_tx.pop_front()});
                start_seen = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (!rst && wr_strobe) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_wr.pop_front();
                chk("wr_addr", {28'd0, wr_addr}, {28'd0, e[11:8]});
                chk("wr_reg", {24'd0, rg(int'(e[11:8]))}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        repeat (3) @(posedge clk);
        #1 rx_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5); send_byte(c); send_byte(a); send_byte(d); send_byte(k);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && exp_wr.size() == 0 && !tx_busy && !start_seen) done = 1;
        end
        if (!done) chk("wait_idle_timeout", 32'd1, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bit got_busy;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        chk("rst_regs_nz", {31'd0, |regs_out}, 32'd0);

        // Write reg3 = 5C
        exp_tx.push_back(8'h06); exp_wr.push_back({4'd3, 8'h5C});
        send_frame(8'h01, 8'h03, 8'h5C, 8'h5E);
        wait_idle();
        chk("reg3", {24'd0, rg(3)}, 32'h5C);
        chk("err_after_wr", {24'd0, err_count}, 32'd0);

        // Read reg3: ACK then data
        exp_tx.push_back(8'h06); exp_tx.push_back(8'h5C);
        send_frame(8'h02, 8'h03, 8'h00, 8'h01);
        wait_idle();

        // Bad checksum
        exp_tx.push_back(8'h15);
        send_frame(8'h01, 8'h02, 8'h11, 8'h00);
        wait_idle();
        chk("reg2_untouched", {24'd0, rg(2)}, 32'd0);
        chk("err_badchk", {24'd0, err_count}, 32'd1);

        // Address out of range
        exp_tx.push_back(8'h15);
        send_frame(8'h02, 8'h10, 8'h00, 8'h12);
        wait_idle();
        chk("err_oor", {24'd0, err_count}, 32'd2);

        // Leading noise, then a byte injected during the ACK transmit
        exp_tx.push_back(8'h06); exp_wr.push_back({4'd0, 8'hAA});
        send_byte(8'hFF); send_byte(8'h00);
        send_frame(8'h01, 8'h00, 8'hAA, 8'hAB);
        got_busy = 0;
        for (int i = 0; i < 2000 && !got_busy; i++) begin
            @(negedge clk);
            if (tx_busy) got_busy = 1;
        end
        chk("busy_seen", {31'd0, got_busy}, 32'd1);
        chk("err_noise", {24'd0, err_count}, 32'd2);
        send_byte(8'h33);
        wait_idle();
        chk("reg0", {24'd0, rg(0)}, 32'hAA);
        chk("err_drop", {24'd0, err_count}, 32'd3);

        // Top register write/read, then an unknown command
        exp_tx.push_back(8'h06); exp_wr.push_back({4'd15, 8'h77});
        send_frame(8'h01, 8'h0F, 8'h77, 8'h79);
        wait_idle();
        exp_tx.push_back(8'h06); exp_tx.push_back(8'h77);
        send_frame(8'h02, 8'h0F, 8'h00, 8'h0D);
        wait_idle();
        exp_tx.push_back(8'h15);
        send_frame(8'h03, 8'h01, 8'h00, 8'h02);
        wait_idle();
        chk("err_badcmd", {24'd0, err_count}, 32'd4);
        chk("reg3_keep", {24'd0, rg(3)}, 32'h5C);

        // Reset mid-frame
        send_byte(8'hA5); send_byte(8'h01);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("mid_rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("mid_rst_err", {24'd0, err_count}, 32'd0);
        chk("mid_rst_regs_nz", {31'd0, |regs_out}, 32'd0);
        exp_tx.push_back(8'h06); exp_wr.push_back({4'd3, 8'h5C});
        send_frame(8'h01, 8'h03, 8'h5C, 8'h5E);
        wait_idle();
        chk("reg3_post_rst", {24'd0, rg(3)}, 32'h5C);

        // Stalled partial frame
        send_byte(8'hA5); send_byte(8'h01);
        repeat (150) @(negedge clk);
        exp_tx.push_back(8'h06); exp_wr.push_back({4'd5, 8'h42});
`ifdef UART_CMD_TIMEOUT_EN
        chk("err_timeout", {24'd0, err_count}, 32'd1);
        send_frame(8'h01, 8'h05, 8'h42, 8'h46);
        wait_idle();
        chk("err_after_to", {24'd0, err_count}, 32'd1);
`else
        chk("err_stall", {24'd0, err_count}, 32'd0);
        send_byte(8'h05); send_byte(8'h42); send_byte(8'h46);
        wait_idle();
        chk("err_after_stall", {24'd0, err_count}, 32'd0);
`endif
        chk("reg5", {24'd0, rg(5)}, 32'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
